// File: rtl/wb_stage_if.sv
// Memory-stage to write-back-stage handshake: valid/allowin plus the
// 174-bit instruction bus carried from the memory stage.
interface wb_stage_if;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [173:0] ms_to_ws_bus;

    // Memory stage side: offers an instruction, watches allowin.
    modport master (
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus
    );

    // Write-back stage side: accepts the instruction.
    modport slave (
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: latches the memory-stage bus, retires the instruction
// (register file, CSR, trace port) and raises the single pipeline flush for
// exceptions, ertn and refetch-class instructions.
module wb_stage #(
    parameter logic [13:0] TID_CSR_NUM = 14'h040
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   ms_if,

    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [4:0]  ws_to_ds_dest,
    output logic [31:0] ws_to_ds_value,
    output logic        ws_csr,
    output logic        ws_tid,

    output logic [13:0] csr_num,
    output logic        csr_re,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,

    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        wb_ertn,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,

    output logic [4:0]  tlb_op,
    output logic        ws_reflush,
    output logic [31:0] flush_target,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic         ws_valid_q, ws_valid_d;
    logic [173:0] ws_bus_q, ws_bus_d;
    logic         ws_ready_go;
    logic         ws_allowin;

    // Latched bus fields
    logic [4:0]  f_tlb_op;
    logic        f_rdcntid;
    logic [31:0] f_vaddr;
    logic        f_ertn;
    logic        f_csr_we;
    logic        f_csr_rd;
    logic [31:0] f_csr_wmask;
    logic [13:0] f_csr_num;
    logic [16:0] f_ex_cause;
    logic        f_gr_we;
    logic [4:0]  f_dest;
    logic [31:0] f_result;
    logic [31:0] f_pc;

    logic        ex;
    logic        ertn_commit;
    logic        refetch;
    logic        commit_ok;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] pc_plus4;

    assign ws_ready_go      = 1'b1;
    assign ws_allowin       = !ws_valid_q || ws_ready_go;
    assign ms_if.ws_allowin = ws_allowin;

    assign f_tlb_op    = ws_bus_q[173:169];
    assign f_rdcntid   = ws_bus_q[168];
    assign f_vaddr     = ws_bus_q[167:136];
    assign f_ertn      = ws_bus_q[135];
    assign f_csr_we    = ws_bus_q[134];
    assign f_csr_rd    = ws_bus_q[133];
    assign f_csr_wmask = ws_bus_q[132:101];
    assign f_csr_num   = ws_bus_q[100:87];
    assign f_ex_cause  = ws_bus_q[86:70];
    assign f_gr_we     = ws_bus_q[69];
    assign f_dest      = ws_bus_q[68:64];
    assign f_result    = ws_bus_q[63:32];
    assign f_pc        = ws_bus_q[31:0];

    // Next-state for the valid bit and the bus latch; a flush kills the
    // incoming instruction so nothing younger slips past a redirect.
    always_comb begin
        ws_valid_d = ws_valid_q;
        ws_bus_d   = ws_bus_q;
        if (ws_reflush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_if.ms_to_ws_valid;
        end
        if (ms_if.ms_to_ws_valid && ws_allowin) begin
            ws_bus_d = ms_if.ms_to_ws_bus;
        end
    end

    // Valid bit is reset; the bus latch deliberately is not.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
        end else begin
            ws_valid_q <= ws_valid_d;
        end
        ws_bus_q <= ws_bus_d;
    end

    // Exception cause priority encoder, highest priority first.
    always_comb begin
        ecode    = 6'h00;
        esubcode = 9'h000;
        if      (f_ex_cause[0])  ecode = 6'h00;
        else if (f_ex_cause[12]) ecode = 6'h08;
        else if (f_ex_cause[13]) ecode = 6'h3F;
        else if (f_ex_cause[14]) ecode = 6'h03;
        else if (f_ex_cause[15]) ecode = 6'h07;
        else if (f_ex_cause[2])  ecode = 6'h0B;
        else if (f_ex_cause[3])  ecode = 6'h0C;
        else if (f_ex_cause[4])  ecode = 6'h0D;
        else if (f_ex_cause[5])  ecode = 6'h0E;
        else if (f_ex_cause[6])  ecode = 6'h09;
        else if (f_ex_cause[7]) begin
            ecode    = 6'h08;
            esubcode = 9'h001;
        end
        else if (f_ex_cause[8])  ecode = 6'h3F;
        else if (f_ex_cause[9])  ecode = 6'h01;
        else if (f_ex_cause[10]) ecode = 6'h02;
        else if (f_ex_cause[11]) ecode = 6'h04;
        else if (f_ex_cause[16]) ecode = 6'h07;
    end

    assign ex          = ws_valid_q && (|f_ex_cause);
    assign commit_ok   = ws_valid_q && !ex;
    assign ertn_commit = commit_ok && f_ertn;
    assign refetch     = commit_ok &&
                         (f_csr_we | f_tlb_op[3] | f_tlb_op[2] | f_tlb_op[1] | f_tlb_op[0]);
    assign pc_plus4    = f_pc + 32'd4;

    // Redirect target: exception entry beats ertn return beats refetch.
    always_comb begin
        flush_target = pc_plus4;
        if (ex) begin
            flush_target = ex_entry;
        end else if (f_ertn) begin
            flush_target = ertn_entry;
        end
    end

    assign ws_reflush  = ex | ertn_commit | refetch;
    assign wb_ex       = ex;
    assign wb_ecode    = ecode;
    assign wb_esubcode = esubcode;
    assign wb_pc       = f_pc;
    assign wb_vaddr    = f_vaddr;
    assign wb_ertn     = ertn_commit;

    assign csr_num    = f_rdcntid ? TID_CSR_NUM : f_csr_num;
    assign csr_re     = ws_valid_q && (f_csr_rd | f_rdcntid);
    assign csr_we     = commit_ok && f_csr_we;
    assign csr_wmask  = f_csr_wmask;
    assign csr_wvalue = f_result;

    assign tlb_op = f_tlb_op & {5{commit_ok}};

    assign rf_we    = commit_ok && f_gr_we;
    assign rf_waddr = f_dest;
    assign rf_wdata = (f_csr_rd | f_rdcntid) ? csr_rvalue : f_result;

    assign ws_to_ds_dest  = rf_we ? rf_waddr : 5'd0;
    assign ws_to_ds_value = rf_we ? rf_wdata : 32'd0;
    assign ws_csr         = ws_valid_q && (f_csr_we | f_csr_rd);
    assign ws_tid         = ws_valid_q && f_rdcntid;

    assign debug_wb_pc       = f_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: one instruction per step, outputs checked
// one time unit after the edge that latched it.
module tb_wb_stage;
    logic        clk;
    logic        reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_to_ds_dest;
    logic [31:0] ws_to_ds_value;
    logic        ws_csr, ws_tid;
    logic [13:0] csr_num;
    logic        csr_re;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        wb_ertn;
    logic [31:0] ex_entry, ertn_entry;
    logic [4:0]  tlb_op;
    logic        ws_reflush;
    logic [31:0] flush_target;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_stage_if ms_if ();

    wb_stage #(.TID_CSR_NUM(14'h040)) dut (
        .clk(clk), .reset(reset), .ms_if(ms_if.slave),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_to_ds_dest(ws_to_ds_dest), .ws_to_ds_value(ws_to_ds_value),
        .ws_csr(ws_csr), .ws_tid(ws_tid),
        .csr_num(csr_num), .csr_re(csr_re), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ertn(wb_ertn),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .tlb_op(tlb_op), .ws_reflush(ws_reflush), .flush_target(flush_target),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [173:0] mk(
        input logic [4:0]  tlb,     input logic        tid,
        input logic [31:0] vaddr,   input logic        ertn,
        input logic        cwe,     input logic        crd,
        input logic [31:0] wmask,   input logic [13:0] cnum,
        input logic [16:0] cause,   input logic        grwe,
        input logic [4:0]  dest,    input logic [31:0] result,
        input logic [31:0] pc);
        return {tlb, tid, vaddr, ertn, cwe, crd, wmask, cnum, cause, grwe, dest, result, pc};
    endfunction

    // Present one instruction, clock it in, settle past the edge.
    task automatic issue(input logic v, input logic [173:0] bus);
        ms_if.ms_to_ws_valid = v;
        ms_if.ms_to_ws_bus   = bus;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ms_if.ms_to_ws_valid = 1'b0;
        ms_if.ms_to_ws_bus   = '0;
        csr_rvalue = 32'h0;
        ex_entry   = 32'h1C00_8000;
        ertn_entry = 32'h1C00_0040;
        @(posedge clk); @(posedge clk); #1;

        $display("step reset");
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_reflush", {31'd0, ws_reflush}, 32'd0);
        chk("rst_wb_ex", {31'd0, wb_ex}, 32'd0);
        chk("rst_csr_re", {31'd0, csr_re}, 32'd0);
        chk("rst_tlb_op", {27'd0, tlb_op}, 32'd0);
        chk("rst_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        chk("rst_fwd_dest", {27'd0, ws_to_ds_dest}, 32'd0);
        chk("rst_allowin", {31'd0, ms_if.ws_allowin}, 32'd1);
        reset = 1'b0;

        $display("step gr write dest=5");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000));
        chk("w_rf_we", {31'd0, rf_we}, 32'd1);
        chk("w_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("w_wdata", rf_wdata, 32'h1234_5678);
        chk("w_dbg_we", {28'd0, debug_wb_rf_we}, 32'hF);
        chk("w_reflush", {31'd0, ws_reflush}, 32'd0);
        chk("w_fwd_val", ws_to_ds_value, 32'h1234_5678);
        chk("w_dbg_pc", debug_wb_pc, 32'h1C00_0000);

        $display("step back-to-back write dest=7");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b1, 5'd7, 32'h0000_DEAD, 32'h1C00_0004));
        chk("b2b_rf_we", {31'd0, rf_we}, 32'd1);
        chk("b2b_fwd_dest", {27'd0, ws_to_ds_dest}, 32'd7);
        chk("b2b_wdata", rf_wdata, 32'h0000_DEAD);

        $display("step bubble");
        issue(1'b0, '0);
        chk("bub_rf_we", {31'd0, rf_we}, 32'd0);

        $display("step ex bits 2+6 with gr_we and csr_we");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 14'd1,
                       17'h00044, 1'b1, 5'd3, 32'h1, 32'h1C00_0010));
        chk("ex_wb_ex", {31'd0, wb_ex}, 32'd1);
        chk("ex_ecode", {26'd0, wb_ecode}, 32'h0B);
        chk("ex_esub", {23'd0, wb_esubcode}, 32'd0);
        chk("ex_reflush", {31'd0, ws_reflush}, 32'd1);
        chk("ex_target", flush_target, 32'h1C00_8000);
        chk("ex_rf_we", {31'd0, rf_we}, 32'd0);
        chk("ex_csr_we", {31'd0, csr_we}, 32'd0);
        chk("ex_wb_pc", wb_pc, 32'h1C00_0010);

        $display("step post-flush kill");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b1, 5'd8, 32'h8, 32'h1C00_0014));
        chk("kill_rf_we", {31'd0, rf_we}, 32'd0);
        chk("kill_reflush", {31'd0, ws_reflush}, 32'd0);

        $display("step ex bit 7 ADEM");
        issue(1'b1, mk(5'd0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'h00080,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0020));
        chk("adem_ecode", {26'd0, wb_ecode}, 32'h08);
        chk("adem_esub", {23'd0, wb_esubcode}, 32'd1);
        chk("adem_vaddr", wb_vaddr, 32'h3);
        issue(1'b0, '0);

        $display("step ex bits 13+2 priority");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'h02004,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0030));
        chk("pri_tlbr", {26'd0, wb_ecode}, 32'h3F);
        issue(1'b0, '0);

        $display("step ex bits 16+11 priority");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'h10800,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0034));
        chk("pri_pme", {26'd0, wb_ecode}, 32'h04);
        issue(1'b0, '0);

        $display("step ertn");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0050));
        chk("ertn_wb_ertn", {31'd0, wb_ertn}, 32'd1);
        chk("ertn_target", flush_target, 32'h1C00_0040);
        chk("ertn_wb_ex", {31'd0, wb_ex}, 32'd0);
        chk("ertn_reflush", {31'd0, ws_reflush}, 32'd1);
        issue(1'b0, '0);

        $display("step ertn with ex bit 4");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 14'd0, 17'h00010,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0054));
        chk("exertn_wb_ertn", {31'd0, wb_ertn}, 32'd0);
        chk("exertn_ecode", {26'd0, wb_ecode}, 32'h0D);
        chk("exertn_target", flush_target, 32'h1C00_8000);
        issue(1'b0, '0);

        $display("step rdcntid dest=4");
        csr_rvalue = 32'hAB;
        issue(1'b1, mk(5'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'h123, 17'd0,
                       1'b1, 5'd4, 32'h9999, 32'h1C00_0060));
        chk("tid_csr_num", {18'd0, csr_num}, 32'h040);
        chk("tid_csr_re", {31'd0, csr_re}, 32'd1);
        chk("tid_wdata", rf_wdata, 32'hAB);
        chk("tid_ws_tid", {31'd0, ws_tid}, 32'd1);
        chk("tid_ws_csr", {31'd0, ws_csr}, 32'd0);
        chk("tid_reflush", {31'd0, ws_reflush}, 32'd0);

        $display("step csr read num=5");
        csr_rvalue = 32'h77;
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 14'h005, 17'd0,
                       1'b1, 5'd9, 32'h1, 32'h1C00_0064));
        chk("crd_csr_num", {18'd0, csr_num}, 32'h005);
        chk("crd_ws_csr", {31'd0, ws_csr}, 32'd1);
        chk("crd_wdata", rf_wdata, 32'h77);
        chk("crd_fwd_val", ws_to_ds_value, 32'h77);

        $display("step tlbsrch");
        issue(1'b1, mk(5'b10000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b0, 5'd0, 32'h0, 32'h1C00_0068));
        chk("srch_tlb_op", {27'd0, tlb_op}, 32'h10);
        chk("srch_reflush", {31'd0, ws_reflush}, 32'd0);

        $display("step tlbwr refetch");
        issue(1'b1, mk(5'b00100, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b0, 5'd0, 32'h0, 32'h1C00_006C));
        chk("wr_tlb_op", {27'd0, tlb_op}, 32'h04);
        chk("wr_reflush", {31'd0, ws_reflush}, 32'd1);
        chk("wr_target", flush_target, 32'h1C00_0070);
        issue(1'b0, '0);

        $display("step csr write at pc wrap, then reset");
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 14'h000, 17'd0,
                       1'b0, 5'd0, 32'h55, 32'hFFFF_FFFC));
        chk("cwe_csr_we", {31'd0, csr_we}, 32'd1);
        chk("cwe_reflush", {31'd0, ws_reflush}, 32'd1);
        chk("cwe_target", flush_target, 32'h0);
        chk("cwe_wvalue", csr_wvalue, 32'h55);
        chk("cwe_wmask", csr_wmask, 32'hFF);
        chk("cwe_ws_csr", {31'd0, ws_csr}, 32'd1);
        reset = 1'b1;
        issue(1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 14'd0, 17'd0,
                       1'b1, 5'd6, 32'h6, 32'h1C00_0080));
        chk("rstf_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rstf_csr_we", {31'd0, csr_we}, 32'd0);
        chk("rstf_reflush", {31'd0, ws_reflush}, 32'd0);
        chk("rstf_ws_csr", {31'd0, ws_csr}, 32'd0);
        chk("rstf_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Final (write-back) pipeline stage of the CPU, directly downstream of the memory stage. It latches the memory-to-write-back bus and retires the instruction: it writes the register file, drives the trace/debug port and performs CSR reads and writes. It also raises the single pipeline-wide flush for exceptions, `ertn` and refetch-class instructions, together with the redirect target. All exception and CSR side effects commit here, so nothing before this stage is architecturally visible.

## Interface
Parameters:
- `TID_CSR_NUM`, default 14'h040: CSR number read by `rdcntid`.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ws_allowin`  out  1: stage can accept from the memory stage.
- `ms_to_ws_valid`  in  1: memory stage has an instruction.
- `ms_to_ws_bus`  in  174: fields are:
  - [173:169] tlb_op, one bit each: {srch, rd, wr, fill, inv}
  - [168] rdcntid
  - [167:136] vaddr
  - [135] ertn
  - [134] csr_we
  - [133] csr_rd
  - [132:101] csr_wmask
  - [100:87] csr_num
  - [86:70] ex_cause[16:0]
  - [69] gr_we
  - [68:64] dest
  - [63:32] result
  - [31:0] pc
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `ws_to_ds_dest`  out  5: forwarding destination; 0 if there is no valid write.
- `ws_to_ds_value`  out  32: forwarding value; 0 if there is no valid write.
- `ws_csr`, `ws_tid`  out  1: the held instruction is a valid CSR access / `rdcntid`; used by decode to stall.
- `csr_num` out 14, `csr_re` out 1, `csr_rvalue` in 32: CSR read port, combinational read.
- `csr_we` out 1, `csr_wmask` out 32, `csr_wvalue` out 32: CSR write port.
- `wb_ex` out 1, `wb_ecode` out 6, `wb_esubcode` out 9, `wb_pc` out 32, `wb_vaddr` out 32: exception commit to the CSR file.
- `wb_ertn`  out  1: `ertn` commit.
- `ex_entry`, `ertn_entry`  in  32: EENTRY/TLBRENTRY (resolved by the CSR file) and ERA.
- `tlb_op`  out  5: qualified TLB command.
- `ws_reflush`  out  1: flush all earlier stages.
- `flush_target`  out  32: redirect PC.
- `debug_wb_pc` out 32, `debug_wb_rf_we` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: trace port.

## Operation
- Registers: `ws_valid`, plus a 174-bit bus latch. The latch loads when `ms_to_ws_valid && ws_allowin`.
- `ws_ready_go` is 1. `ws_allowin` = `!ws_valid || ws_ready_go` (always 1).
- `ws_valid` update:
  - `reset` → 0.
  - Else if `ws_reflush` → 0.
  - Else if `ws_allowin` → `ms_to_ws_valid`.
- `ex` = `ws_valid && |ex_cause`. A one-hot priority encoder picks the cause, highest priority first (bit: ecode/esubcode):
  - 0 INT 0x00
  - 12 ADEF 0x08/0
  - 13 TLBR 0x3F
  - 14 PIF 0x03
  - 15 PPI 0x07
  - 2 SYS 0x0B
  - 3 BRK 0x0C
  - 4 INE 0x0D
  - 5 IPE 0x0E
  - 6 ALE 0x09
  - 7 ADEM 0x08/1
  - 8 TLBR 0x3F
  - 9 PIL 0x01
  - 10 PIS 0x02
  - 11 PME 0x04
  - 16 PPI 0x07
  - esubcode is 0 except for ADEM.
- `wb_ex` = `ex`. `wb_pc` = pc. `wb_vaddr` = vaddr.
- `wb_ertn` = `ws_valid && ertn && !ex`.
- `refetch` = `ws_valid && !ex && (csr_we | tlb_op[3] | tlb_op[2] | tlb_op[1] | tlb_op[0])`.
- `ws_reflush` = `ex | wb_ertn | refetch`.
- `flush_target` priority: `ex` → `ex_entry`; else `ertn` → `ertn_entry`; else pc+4 (32-bit wrap).
- CSR port:
  - `csr_num` = rdcntid ? `TID_CSR_NUM` : csr_num field.
  - `csr_re` = `ws_valid && (csr_rd | rdcntid)`.
  - `csr_we` out = `ws_valid && csr_we && !ex`.
  - `csr_wvalue` = result field.
- `tlb_op` out = tlb_op field & {5{`ws_valid && !ex`}}.
- Register-file write:
  - `rf_we` = `ws_valid && gr_we && !ex`.
  - `rf_waddr` = dest.
  - `rf_wdata` = (csr_rd | rdcntid) ? `csr_rvalue` : result.
- Forwarding: `ws_to_ds_dest`/`ws_to_ds_value` = `rf_waddr`/`rf_wdata` gated by `rf_we`, else 0.
- Stall flags: `ws_csr` = `ws_valid && (csr_we | csr_rd)`; `ws_tid` = `ws_valid && rdcntid`.
- Trace port: `debug_wb_pc` = pc; `debug_wb_rf_we` = {4{`rf_we`}}; `debug_wb_rf_wnum` = `rf_waddr`; `debug_wb_rf_wdata` = `rf_wdata`.

## Timing
- Latency: an instruction accepted at edge N retires during cycle N..N+1. All outputs are combinational from `ws_valid` and the latch.
- Reset values: `ws_valid`=0. Every qualified output is therefore 0: `rf_we`, `csr_re`, `csr_we`, `wb_ex`, `wb_ertn`, `ws_reflush`, `tlb_op`, `ws_csr`, `ws_tid`, forwarding outputs, `debug_wb_rf_we`. The bus latch is not reset.
- `ws_reflush` is high for exactly the one cycle the faulting or redirecting instruction is in this stage. At the next edge `ws_valid` becomes 0 even if `ms_to_ws_valid` is 1.
- Simultaneous `ex` and `ertn`: exception wins; no `wb_ertn`.
- Simultaneous `ex` and `csr_we`/`gr_we`: no CSR or register write.
- `reset` asserted mid-flush: `ws_valid` becomes 0 and no further side effects occur.
- Back-to-back instructions retire one per cycle without bubbles.

## Test plan
- `gr_we=1`, dest=5, result=0x1234_5678, pc=0x1C00_0000 → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x12345678, `debug_wb_rf_we`=4'hF, `ws_reflush`=0.
- `ex_cause` bits 2 and 6 set, `ex_entry`=0x1C00_8000 → `wb_ecode`=0x0B, `ws_reflush`=1, `flush_target`=0x1C008000, `rf_we`=0. Next cycle `ws_valid`=0 despite `ms_to_ws_valid`=1.
- ex bit 7 only, vaddr=0x0000_0003 → `wb_ecode`=0x08, `wb_esubcode`=1, `wb_vaddr`=3.
- `ertn`, `ertn_entry`=0x1C00_0040 → `wb_ertn`=1, `flush_target`=0x1C000040, `wb_ex`=0.
- `rdcntid`, dest=4, `csr_rvalue`=0xAB → `csr_num`=0x040, `csr_re`=1, `rf_wdata`=0xAB, `ws_tid`=1.
- `csr_we`, csr_num=0x0, pc=0xFFFF_FFFC → `csr_we`=1, `ws_reflush`=1, `flush_target`=0x0 (wrap). `reset` asserted in the same cycle → all outputs 0 the next cycle.
